// File: rtl/des_pipe_ctrl_if.sv
// des_pipe_ctrl_if: request, datapath, result and scan-control signals of des_pipe_ctrl
interface des_pipe_ctrl_if;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_text, req1_text, req0_key, req1_key;
  logic        req0_decrypt, req1_decrypt;
  logic [63:0] des_text, des_key, des_ciphertext;
  logic        des_decrypt;
  logic        res_valid, res_ready, res_id;
  logic [63:0] res_data;
  logic        test_mode, scan_start, scan_busy, scan_done;
  modport master (
    output req0_valid, req1_valid, req0_text, req1_text, req0_key, req1_key,
           req0_decrypt, req1_decrypt, des_ciphertext, res_ready, scan_start,
    input  req0_ready, req1_ready, des_text, des_key, des_decrypt,
           res_valid, res_data, res_id, test_mode, scan_busy, scan_done
  );
  modport slave (
    input  req0_valid, req1_valid, req0_text, req1_text, req0_key, req1_key,
           req0_decrypt, req1_decrypt, des_ciphertext, res_ready, scan_start,
    output req0_ready, req1_ready, des_text, des_key, des_decrypt,
           res_valid, res_data, res_id, test_mode, scan_busy, scan_done
  );
endinterface

// File: rtl/des_pipe_ctrl.sv
// des_pipe_ctrl: round-robin issue into a LAT-deep DES datapath with a credit-guarded result FIFO; scan sequencer enabled by DES_SCAN_CTRL_EN
module des_pipe_ctrl #(
  parameter int LAT        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  des_pipe_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [CW-1:0]  credits_q;
  logic           last_q;
  logic [LAT-1:0] vld_q, id_q;
  logic [AW:0]    wptr_q, rptr_q;
  logic [64:0]    mem_q [FIFO_DEPTH];
  logic [63:0]    text_q, key_q;
  logic           dec_q, blk, can_issue, g0, g1, issue, push, pop;
  // last_q = 1 means req1 was granted last, so req0 wins the next tie
  assign can_issue = !rst && credits_q != '0 && !blk && !bus.test_mode;
  assign g0 = can_issue && bus.req0_valid && (!bus.req1_valid || last_q);
  assign g1 = can_issue && bus.req1_valid && (!bus.req0_valid || !last_q);
  assign issue = g0 || g1;
  assign push = vld_q[LAT-1];
  assign pop = bus.res_valid && bus.res_ready;
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.des_text = text_q;
  assign bus.des_key = key_q;
  assign bus.des_decrypt = dec_q;
  assign bus.res_valid = wptr_q != rptr_q;
  assign {bus.res_id, bus.res_data} = mem_q[rptr_q[AW-1:0]];
  // issue capture, arbiter pointer, in-flight tracking, FIFO pointers and credits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      text_q    <= '0;
      key_q     <= '0;
      dec_q     <= 1'b0;
      last_q    <= 1'b1;
      vld_q     <= '0;
      id_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      credits_q <= CW'(FIFO_DEPTH);
    end else begin
      if (issue) begin
        text_q <= g1 ? bus.req1_text : bus.req0_text;
        key_q  <= g1 ? bus.req1_key : bus.req0_key;
        dec_q  <= g1 ? bus.req1_decrypt : bus.req0_decrypt;
        last_q <= g1;
      end
      vld_q     <= {vld_q[LAT-2:0], issue};
      id_q      <= {id_q[LAT-2:0], g1};
      wptr_q    <= wptr_q + {{AW{1'b0}}, push};
      rptr_q    <= rptr_q + {{AW{1'b0}}, pop};
      credits_q <= credits_q + {{(CW-1){1'b0}}, pop} - {{(CW-1){1'b0}}, issue};
    end
  // result storage; entries are qualified by the pointers so they need no reset
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q[AW-1:0]] <= {id_q[LAT-1], bus.des_ciphertext};
`ifdef DES_SCAN_CTRL_EN
  typedef enum logic [1:0] {IDLE, DRAIN, SCAN} state_t;
  state_t     state_q, state_d;
  logic [8:0] cnt_q;
  logic       done_q;
  // scan state register, 512-cycle SCAN timer and completion pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == SCAN ? cnt_q + 9'd1 : '0;
      done_q  <= state_q == SCAN && state_d == IDLE;
    end
  // DRAIN holds the latched request (blocking issue) until no operation is in flight
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = bus.scan_start ? DRAIN : IDLE;
    else if (state_q == DRAIN) state_d = |vld_q ? DRAIN : SCAN;
    else state_d = cnt_q == 9'd511 ? IDLE : SCAN;
  end
  assign blk = state_q != IDLE;
  assign bus.test_mode = state_q == SCAN;
  assign bus.scan_busy = state_q == SCAN;
  assign bus.scan_done = done_q;
`else
  logic unused_scan_start;
  assign unused_scan_start = bus.scan_start;
  assign blk = 1'b0;
  assign bus.test_mode = 1'b0;
  assign bus.scan_busy = 1'b0;
  assign bus.scan_done = 1'b0;
`endif
endmodule

// File: tb/tb_des_pipe_ctrl.sv
// tb_des_pipe_ctrl: randomized scoreboard bench for des_pipe_ctrl with a stand-in LAT-cycle datapath
module tb_des_pipe_ctrl;
  localparam int LAT = 16;
  localparam int FIFO_DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  des_pipe_ctrl_if bus();
  des_pipe_ctrl #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared = 0, mismatched = 0;

  // stand-in for the DES core: any fixed mixing function works, it only has to be traceable
  function automatic logic [63:0] dp(input logic [63:0] t, input logic [63:0] k, input logic d);
    return {t[40:0], t[63:41]} ^ k ^ {64{d}};
  endfunction

  logic [63:0] hist [LAT-1];
  always @(posedge clk) begin
    hist[0] <= dp(bus.des_text, bus.des_key, bus.des_decrypt);
    for (int i = 1; i < LAT - 1; i++) hist[i] <= hist[i-1];
  end
  assign bus.des_ciphertext = hist[LAT-2];

  logic [64:0] exp_q[$], got_q[$];
  int          iss_cyc[$], got_cyc[$];
  logic        grants[$];
  int cyc = 0, n_iss = 0, rv_seen = 0, cred = FIFO_DEPTH;
  int both_err = 0, rdy_err = 0, rr_err = 0, stab_err = 0;
  logic last_g = 1'b1, m_iss, m_g, prev_hold = 1'b0, prev_id;
  logic [63:0] prev_data;
  bit scan_pend = 0;

  // observer: records issues/results and checks per-cycle handshake rules against a credit model
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete(); got_q.delete(); iss_cyc.delete(); got_cyc.delete(); grants.delete();
      cred = FIFO_DEPTH; last_g = 1'b1; prev_hold = 1'b0;
    end else begin
      m_iss = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
      m_g = bus.req1_valid && bus.req1_ready;
      if (bus.req0_ready && bus.req1_ready) both_err++;
      if (!scan_pend && ((bus.req0_ready || bus.req1_ready) !==
          (cred > 0 && (bus.req0_valid || bus.req1_valid) && !bus.test_mode))) rdy_err++;
      if (m_iss) begin
        if (bus.req0_valid && bus.req1_valid && m_g == last_g) rr_err++;
        last_g = m_g;
        exp_q.push_back(m_g ? {1'b1, dp(bus.req1_text, bus.req1_key, bus.req1_decrypt)}
                            : {1'b0, dp(bus.req0_text, bus.req0_key, bus.req0_decrypt)});
        iss_cyc.push_back(cyc);
        grants.push_back(m_g);
        n_iss++;
      end
      if (prev_hold && {bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, prev_id, prev_data}) stab_err++;
      prev_hold = bus.res_valid && !bus.res_ready;
      prev_id = bus.res_id;
      prev_data = bus.res_data;
      if (bus.res_valid) rv_seen++;
      if (bus.res_valid && bus.res_ready) begin
        got_q.push_back({bus.res_id, bus.res_data});
        got_cyc.push_back(cyc);
        cred++;
      end
      if (m_iss) cred--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); iss_cyc.delete(); got_cyc.delete(); grants.delete();
  endtask

  task automatic rand_data();
    bus.req0_text = {$urandom, $urandom}; bus.req0_key = {$urandom, $urandom};
    bus.req1_text = {$urandom, $urandom}; bus.req1_key = {$urandom, $urandom};
    bus.req0_decrypt = 1'($urandom); bus.req1_decrypt = 1'($urandom);
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.req0_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b expected 0", bus.req0_ready); end
    compared++;
    if ({bus.res_valid, bus.test_mode, bus.scan_busy, bus.scan_done} !== 4'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b expected 0000", {bus.res_valid, bus.test_mode, bus.scan_busy, bus.scan_done});
    end
    compared++;
    if ({bus.des_text, bus.des_key, bus.des_decrypt} !== 129'b0) begin
      mismatched++; $display("FAIL reset_des: got %h/%h/%b expected zeros", bus.des_text, bus.des_key, bus.des_decrypt);
    end
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.res_valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_res_valid: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_single();
    bit ok = 0;
    logic [63:0] ct, e;
    tick();
    clear_sb();
    bus.res_ready = 1'b1;
    bus.req0_text = 64'h0123456789ABCDEF; bus.req0_key = 64'h133457799BBCDFF1; bus.req0_decrypt = 1'b0;
    bus.req0_valid = 1'b1;
    e = dp(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = bus.req0_ready; end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL single_grant: got no grant expected grant"); end
    tick();
    bus.req0_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    ct = bus.des_ciphertext;
    for (int i = 0; i < 40 && got_q.size() == 0; i++) tick();
    compared++;
    if (got_q.size() != 1 || iss_cyc.size() != 1) begin
      mismatched++; $display("FAIL single_count: got %0d results expected 1", got_q.size());
    end else begin
      compared++;
      if (got_cyc[0] - iss_cyc[0] != LAT + 1) begin mismatched++; $display("FAIL single_latency: got %0d expected %0d", got_cyc[0] - iss_cyc[0], LAT + 1); end
      compared++;
      if (got_q[0] !== {1'b0, ct}) begin mismatched++; $display("FAIL single_vs_datapath: got %h expected %h", got_q[0], {1'b0, ct}); end
      compared++;
      if (got_q[0] !== {1'b0, e}) begin mismatched++; $display("FAIL single_data: got %h expected %h", got_q[0], {1'b0, e}); end
    end
  endtask

  task automatic test_alternate();
    logic start;
    tick();
    clear_sb();
    rr_err = 0;
    start = last_g;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (40) begin tick(); rand_data(); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
    compared++;
    if (grants.size() < 4) begin mismatched++; $display("FAIL alt_count: got %0d grants expected >= 4", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      compared++;
      if (grants[i] !== ((i % 2 == 0) ? !start : start)) begin
        mismatched++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, grants[i], (i % 2 == 0) ? !start : start);
      end
    end
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL alt_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < got_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL alt_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  task automatic test_backpressure();
    int n0;
    tick();
    clear_sb();
    stab_err = 0;
    n0 = n_iss;
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (30) begin tick(); rand_data(); end
    @(negedge clk);
    #1;
    compared++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin mismatched++; $display("FAIL bp_readies: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    compared++;
    if (bus.res_valid !== 1'b1) begin mismatched++; $display("FAIL bp_res_valid: got %b expected 1", bus.res_valid); end
    compared++;
    if (n_iss - n0 != FIFO_DEPTH) begin mismatched++; $display("FAIL bp_issues: got %0d expected %0d", n_iss - n0, FIFO_DEPTH); end
    tick();
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) tick();
    compared++;
    if (got_q.size() != FIFO_DEPTH || exp_q.size() != FIFO_DEPTH) begin
      mismatched++; $display("FAIL bp_drain: got %0d results expected %0d", got_q.size(), FIFO_DEPTH);
    end else
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL bp_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    compared++;
    if (stab_err != 0) begin mismatched++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_midreset();
    int n0, rv0;
    tick();
    clear_sb();
    n0 = n_iss;
    bus.res_ready = 1'b1;
    rand_data();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 20 && n_iss - n0 < 3; i++) tick();
    bus.req0_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rv0 = rv_seen;
    repeat (40) tick();
    compared++;
    if (rv_seen != rv0) begin mismatched++; $display("FAIL mr_no_results: got %0d valid cycles expected 0", rv_seen - rv0); end
    n0 = n_iss;
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (30) begin tick(); rand_data(); end
    compared++;
    if (n_iss - n0 != FIFO_DEPTH) begin mismatched++; $display("FAIL mr_credits: got %0d issues expected %0d", n_iss - n0, FIFO_DEPTH); end
    bus.req0_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) tick();
    compared++;
    if (got_q.size() != FIFO_DEPTH) begin
      mismatched++; $display("FAIL mr_drain: got %0d results expected %0d", got_q.size(), FIFO_DEPTH);
    end else
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL mr_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  task automatic test_random();
    tick();
    clear_sb();
    both_err = 0; rdy_err = 0; rr_err = 0; stab_err = 0;
    repeat (300) begin
      tick();
      rand_data();
      bus.req0_valid = $urandom_range(0, 3) != 0;
      bus.req1_valid = $urandom_range(0, 3) != 0;
      bus.res_ready = 1'($urandom);
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b1;
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
    compared++;
    if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      mismatched++; $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < got_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rnd_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    compared++;
    if (both_err != 0) begin mismatched++; $display("FAIL rnd_one_ready: got %0d double grants expected 0", both_err); end
    compared++;
    if (rdy_err != 0) begin mismatched++; $display("FAIL rnd_credit_ready: got %0d bad cycles expected 0", rdy_err); end
    compared++;
    if (rr_err != 0) begin mismatched++; $display("FAIL rnd_round_robin: got %0d repeats expected 0", rr_err); end
    compared++;
    if (stab_err != 0) begin mismatched++; $display("FAIL rnd_stable: got %0d changes expected 0", stab_err); end
  endtask

`ifdef DES_SCAN_CTRL_EN
  task automatic test_scan();
    int n0, n_last, tm_cnt = 0, busy_bad = 0;
    bit ok = 0;
    tick();
    clear_sb();
    n0 = n_iss;
    bus.res_ready = 1'b1;
    rand_data();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 20 && n_iss - n0 < 2; i++) tick();
    bus.req0_valid = 1'b0;
    bus.scan_start = 1'b1;
    scan_pend = 1;
    tick();
    bus.scan_start = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    n0 = n_iss;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); #1; ok = bus.test_mode; end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL scan_enter: got test_mode 0 expected 1"); end
    compared++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      mismatched++; $display("FAIL scan_prior_ops: got %0d results expected 2", got_q.size());
    end else
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL scan_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    n_last = n_iss;
    while (bus.test_mode === 1'b1 && tm_cnt < 600) begin
      tm_cnt++;
      if (bus.scan_busy !== 1'b1) busy_bad++;
      n_last = n_iss;
      @(negedge clk);
      #1;
    end
    compared++;
    if (tm_cnt != 512) begin mismatched++; $display("FAIL scan_length: got %0d expected 512", tm_cnt); end
    compared++;
    if (busy_bad != 0) begin mismatched++; $display("FAIL scan_busy: got %0d low cycles expected 0", busy_bad); end
    compared++;
    if (n_last != n0) begin mismatched++; $display("FAIL scan_blocked: got %0d issues expected 0", n_last - n0); end
    compared++;
    if ({bus.scan_done, bus.scan_busy} !== 2'b10) begin mismatched++; $display("FAIL scan_done: got %b expected 10", {bus.scan_done, bus.scan_busy}); end
    scan_pend = 0;
    @(negedge clk);
    #1;
    compared++;
    if (bus.scan_done !== 1'b0) begin mismatched++; $display("FAIL scan_done_pulse: got %b expected 0", bus.scan_done); end
    compared++;
    if (n_iss <= n_last) begin mismatched++; $display("FAIL scan_resume: got %0d new issues expected > 0", n_iss - n_last); end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
  endtask
`else
  task automatic test_scan();
    int n0, bad = 0;
    tick();
    clear_sb();
    rdy_err = 0;
    n0 = n_iss;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.test_mode || bus.scan_busy || bus.scan_done) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL scan_tied: got %0d active cycles expected 0", bad); end
    compared++;
    if (n_iss == n0) begin mismatched++; $display("FAIL scan_ignored: got 0 issues expected > 0"); end
    compared++;
    if (rdy_err != 0) begin mismatched++; $display("FAIL scan_ignored_ready: got %0d bad cycles expected 0", rdy_err); end
    tick();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
  endtask
`endif

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b0; bus.scan_start = 1'b0;
    bus.req0_text = '0; bus.req1_text = '0; bus.req0_key = '0; bus.req1_key = '0;
    bus.req0_decrypt = 1'b0; bus.req1_decrypt = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_midreset();
    test_random();
    test_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
